// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch path: datapath widths, IR field
// positions and the fetch FSM state encoding.
package sisc_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 32;

    // IR field positions
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned MM_MSB  = 27;
    localparam int unsigned MM_LSB  = 24;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    localparam int unsigned OPC_W = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned MM_W  = MM_MSB - MM_LSB + 1;
    localparam int unsigned IMM_W = IMM_MSB - IMM_LSB + 1;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/br_addr_gen.sv
// Next-PC generator: sequential increment, absolute branch or PC-relative
// branch with a signed immediate. All arithmetic wraps at 2^ADDR_W.
// Ports:
//   pc_i      current PC
//   imm_i     immediate field of the IR
//   pc_sel_i  0: PC+1, 1: branch target
//   br_sel_i  0: absolute target, 1: relative target
//   next_pc_o selected next PC
module br_addr_gen
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W = sisc_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic              pc_sel_i,
    input  logic              br_sel_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] imm_abs;
    logic [ADDR_W-1:0] imm_sx;

    // Immediate is zero-extended as an absolute target, sign-extended as an offset
    always_comb begin
        pc_inc  = pc_i + ADDR_W'(1);
        imm_abs = ADDR_W'(imm_i);
        imm_sx  = ADDR_W'($signed(imm_i));
        if (!pc_sel_i) begin
            next_pc_o = pc_inc;
        end else if (!br_sel_i) begin
            next_pc_o = imm_abs;
        end else begin
            next_pc_o = pc_inc + imm_sx;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, the IR and a two-state fetch FSM
// that issues one instruction-memory read per ir_load request.
// Ports:
//   clk, rst_f                  clock, synchronous active-low reset
//   pc_rst, pc_write            PC clear / PC load from next-PC
//   pc_sel, br_sel              next-PC source selection
//   ir_load                     start a fetch at the current PC
//   imem_req, imem_addr         memory read request and address
//   imem_rdata, imem_ack        memory read data and one-cycle completion
//   fetch_busy                  fetch outstanding
//   pc_out, ir                  PC and IR registers
//   opcode, mm, imm             decoded IR fields
module fetch_unit
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W  = sisc_pkg::ADDR_W,
    parameter int unsigned INSTR_W = sisc_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic               fetch_busy,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] ir,
    output logic [OPC_W-1:0]   opcode,
    output logic [MM_W-1:0]    mm,
    output logic [IMM_W-1:0]   imm
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  fetch_addr_q, fetch_addr_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  next_pc;

    br_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_br_addr_gen (
        .pc_i      (pc_q),
        .imm_i     (ir_q[IMM_MSB:IMM_LSB]),
        .pc_sel_i  (pc_sel),
        .br_sel_i  (br_sel),
        .next_pc_o (next_pc)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; pc_rst aborts an outstanding fetch even if ack arrives
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH_IDLE: if (ir_load)              state_d = FETCH_WAIT;
            FETCH_WAIT: if (pc_rst || imem_ack)   state_d = FETCH_IDLE;
            default:                              state_d = FETCH_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        imem_req   = 1'b0;
        fetch_busy = 1'b0;
        if (state_q == FETCH_WAIT) begin
            imem_req   = 1'b1;
            fetch_busy = 1'b1;
        end
    end

    // Datapath next values; fetch_addr captures the pre-update PC
    always_comb begin
        pc_d         = pc_q;
        fetch_addr_d = fetch_addr_q;
        ir_d         = ir_q;
        if (pc_rst) begin
            pc_d = '0;
        end else if (pc_write) begin
            pc_d = next_pc;
        end
        if (state_q == FETCH_IDLE && ir_load) begin
            fetch_addr_d = pc_q;
        end
        if (state_q == FETCH_WAIT && imem_ack && !pc_rst) begin
            ir_d = imem_rdata;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            pc_q         <= '0;
            fetch_addr_q <= '0;
            ir_q         <= '0;
        end else begin
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            ir_q         <= ir_d;
        end
    end

    assign imem_addr = fetch_addr_q;
    assign pc_out    = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[OPC_MSB:OPC_LSB];
    assign mm        = ir_q[MM_MSB:MM_LSB];
    assign imm       = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_f;
    logic        pc_rst;
    logic        pc_write;
    logic        pc_sel;
    logic        br_sel;
    logic        ir_load;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        fetch_busy;
    logic [15:0] pc_out;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state
    int unsigned m_pc   = 0;
    int unsigned m_addr = 0;
    logic [31:0] m_ir   = '0;
    bit          m_busy = 0;

    fetch_unit dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .fetch_busy (fetch_busy),
        .pc_out     (pc_out),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .imm        (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next PC from the arithmetic rules, 16-bit wrap
    function automatic int unsigned model_next_pc(int unsigned pc, logic [31:0] irv,
                                                  logic sel, logic bsel);
        int unsigned im = int'(irv[15:0]);
        int          ims = (im >= 32768) ? int'(im) - 65536 : int'(im);
        if (!sel)  return (pc + 1) % 65536;
        if (!bsel) return im;
        return int'(int'(pc) + 1 + ims) & 32'hFFFF;
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic cyc();
        int unsigned np;
        @(posedge clk);
        if (!rst_f) begin
            m_pc = 0; m_addr = 0; m_ir = '0; m_busy = 0;
        end else begin
            np = pc_rst ? 0 : (pc_write ? model_next_pc(m_pc, m_ir, pc_sel, br_sel) : m_pc);
            if (!m_busy) begin
                if (ir_load) begin
                    m_addr = m_pc;
                    m_busy = 1;
                end
            end else if (pc_rst) begin
                m_busy = 0;
            end else if (imem_ack) begin
                m_ir   = imem_rdata;
                m_busy = 0;
            end
            m_pc = np;
        end
        #1;
        check("pc",     32'(pc_out),     m_pc);
        check("ir",     ir,              m_ir);
        check("opcode", 32'(opcode),     32'(m_ir[31:28]));
        check("mm",     32'(mm),         32'(m_ir[27:24]));
        check("imm",    32'(imm),        32'(m_ir[15:0]));
        check("req",    32'(imem_req),   32'(m_busy));
        check("busy",   32'(fetch_busy), 32'(m_busy));
        if (m_busy) check("addr", 32'(imem_addr), m_addr);
    endtask

    // Fetch with ack lat cycles after the ir_load cycle
    task automatic do_fetch(input logic [31:0] data, input int lat);
        ir_load = 1'b1;
        cyc();
        ir_load = 1'b0;
        repeat (lat - 1) cyc();
        imem_ack   = 1'b1;
        imem_rdata = data;
        cyc();
        imem_ack = 1'b0;
    endtask

    // Load PC with an absolute branch through a fetched immediate
    task automatic set_pc(input logic [15:0] val);
        do_fetch({16'h0000, val}, 1);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
        cyc();
        pc_write = 1'b0; pc_sel = 1'b0;
    endtask

    initial begin
        rst_f = 1'b0; pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0;
        br_sel = 1'b0; ir_load = 1'b0; imem_ack = 1'b0; imem_rdata = '0;

        repeat (2) cyc();
        rst_f = 1'b1;
        check("rst_pc",   32'(pc_out),     32'h0);
        check("rst_ir",   ir,              32'h0);
        check("rst_req",  32'(imem_req),   32'h0);
        check("rst_busy", 32'(fetch_busy), 32'h0);

        // Fetch with ack three cycles after ir_load
        ir_load = 1'b1;
        cyc();
        ir_load = 1'b0;
        check("f1_addr", 32'(imem_addr), 32'h0);
        check("f1_req",  32'(imem_req),  32'h1);
        cyc();
        check("f1_addr2", 32'(imem_addr), 32'h0);
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'h8800_0005;
        cyc();
        imem_ack = 1'b0;
        check("f1_ir",  ir,            32'h8800_0005);
        check("f1_opc", 32'(opcode),   32'h8);
        check("f1_mm",  32'(mm),       32'h8);
        check("f1_imm", 32'(imm),      32'h0005);
        check("f1_busy", 32'(fetch_busy), 32'h0);

        // Absolute branch
        set_pc(16'h0010);
        do_fetch(32'h0000_0040, 2);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b0;
        cyc();
        pc_write = 1'b0; pc_sel = 1'b0;
        check("br_abs", 32'(pc_out), 32'h0040);

        // Relative branch with negative offset
        set_pc(16'h0010);
        do_fetch(32'h0000_FFFE, 1);
        pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
        cyc();
        pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
        check("br_rel", 32'(pc_out), 32'h000F);

        // Sequential wrap at the top of the address space
        set_pc(16'hFFFF);
        pc_write = 1'b1;
        cyc();
        pc_write = 1'b0;
        check("wrap", 32'(pc_out), 32'h0000);

        // pc_rst aborts an outstanding fetch; later ack ignored
        set_pc(16'h0007);
        ir_load = 1'b1;
        cyc();
        ir_load = 1'b0;
        check("ab_addr", 32'(imem_addr), 32'h0007);
        pc_rst = 1'b1;
        cyc();
        pc_rst = 1'b0;
        check("ab_pc",   32'(pc_out),     32'h0);
        check("ab_req",  32'(imem_req),   32'h0);
        check("ab_busy", 32'(fetch_busy), 32'h0);
        cyc();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        cyc();
        imem_ack = 1'b0;
        check("ab_ir", ir, 32'h0000_0007);

        // ir_load and pc_write together use the pre-update PC
        set_pc(16'h0003);
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        cyc();
        ir_load = 1'b0; pc_write = 1'b0;
        check("sim_addr", 32'(imem_addr), 32'h0003);
        check("sim_pc",   32'(pc_out),    32'h0004);
        // pc_write during the wait leaves the address alone
        pc_write = 1'b1;
        cyc();
        pc_write = 1'b0;
        check("sim_addr2", 32'(imem_addr), 32'h0003);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        imem_ack = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_f      = ($urandom_range(0, 99) != 0);
            pc_rst     = ($urandom_range(0, 19) == 0);
            ir_load    = !pc_rst && ($urandom_range(0, 2) == 0);
            pc_write   = ($urandom_range(0, 2) == 0);
            pc_sel     = 1'($urandom);
            br_sel     = 1'($urandom);
            imem_ack   = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            imem_rdata = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
